// File: rtl/dff_pipe.sv
// dff_pipe: elastic valid/ready register pipeline with bubble collapsing.
// Define DFF_PIPE_FLUSH_EN to add the synchronous flush port clr_i.
module dff_pipe #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    STAGES     = 2,
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
`ifdef DFF_PIPE_FLUSH_EN
  input  logic                         clr_i,
`endif
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [DATA_WIDTH-1:0]        dat_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [DATA_WIDTH-1:0]        dat_o,
  output logic [$clog2(STAGES+1)-1:0]  cnt_o
);

  localparam int CW = $clog2(STAGES+1);

  logic                  clr;
  logic [STAGES-1:0]     vld_q;
  logic [STAGES-1:0]     vld_n;
  logic [STAGES-1:0]     adv;
  logic [STAGES-1:0]     ld;
  logic [DATA_WIDTH-1:0] dat_q [STAGES];
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_n;
  logic                  go;
  logic                  in_xfer;
  logic                  out_xfer;

`ifdef DFF_PIPE_FLUSH_EN
  assign clr = clr_i;
`else
  assign clr = 1'b0;
`endif

  // A stage moves on when some later stage is empty or the last one drains.
  always_comb begin
    go  = ready_i;
    adv = '0;
    for (int k = STAGES-1; k >= 0; k--) begin
      adv[k] = vld_q[k] & go;
      go     = go | ~vld_q[k];
    end
  end

  assign ready_o  = ~clr & (~vld_q[0] | adv[0]);
  assign in_xfer  = valid_i & ready_o;
  assign out_xfer = adv[STAGES-1];

  // Next valid bits and per-stage data load enables; flush drops all words.
  always_comb begin
    ld       = '0;
    vld_n    = '0;
    ld[0]    = in_xfer;
    vld_n[0] = in_xfer | (vld_q[0] & ~adv[0]);
    for (int k = 1; k < STAGES; k++) begin
      ld[k]    = adv[k-1];
      vld_n[k] = adv[k-1] | (vld_q[k] & ~adv[k]);
    end
    if (clr) begin
      ld    = '0;
      vld_n = '0;
    end
  end

  // Occupancy follows accepted minus delivered words.
  always_comb begin
    cnt_n = cnt_q + CW'(in_xfer) - CW'(out_xfer);
    if (clr) cnt_n = '0;
  end

  // Stage registers; data only moves when a stage takes a new word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      cnt_q <= '0;
      for (int k = 0; k < STAGES; k++) dat_q[k] <= RST_VAL;
    end else begin
      vld_q <= vld_n;
      cnt_q <= cnt_n;
      if (ld[0]) dat_q[0] <= dat_i;
      for (int k = 1; k < STAGES; k++) begin
        if (ld[k]) dat_q[k] <= dat_q[k-1];
      end
    end
  end

  assign valid_o = vld_q[STAGES-1];
  assign dat_o   = dat_q[STAGES-1];
  assign cnt_o   = cnt_q;

endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: scoreboard bench for dff_pipe (8 bit, 3 stages).
// Flush scenario is exercised when DFF_PIPE_FLUSH_EN is defined.
module tb_dff_pipe;

  localparam int          DW = 8;
  localparam int          ST = 3;
  localparam logic [7:0]  RV = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] dat_i;
  logic       valid_o;
  logic       ready_i;
  logic [7:0] dat_o;
  logic [1:0] cnt_o;
`ifdef DFF_PIPE_FLUSH_EN
  logic       clr_i;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;
  int cyc = 0;
  int v_pct = 0;
  int r_pct = 0;
  int last_acc = 0;
  int last_out = 0;
  bit drv_en = 1'b0;
  bit acc = 1'b0;
  bit stall_prev = 1'b0;
  bit watch77 = 1'b0;
  bit saw77 = 1'b0;
  logic [7:0] prev_d;
  logic [7:0] src_q [$];
  logic [7:0] exp_q [$];

  dff_pipe #(
    .DATA_WIDTH(DW),
    .STAGES(ST),
    .RST_VAL(RV)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
`ifdef DFF_PIPE_FLUSH_EN
    .clr_i(clr_i),
`endif
    .valid_i(valid_i),
    .ready_o(ready_o),
    .dat_i(dat_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .dat_o(dat_o),
    .cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic monitor_cycle();
    bit in_f;
    bit out_f;
    logic [7:0] e;
    if (rst_i) begin
      exp_q.delete();
      stall_prev = 1'b0;
      acc = 1'b0;
    end else begin
      check("cnt", 32'(cnt_o), 32'(exp_q.size()));
      if (stall_prev) begin
        check("hold_v", 32'(valid_o), 32'd1);
        check("hold_d", 32'(dat_o), 32'(prev_d));
      end
      if (watch77 && valid_o && dat_o == 8'h77) saw77 = 1'b1;
      out_f = valid_o & ready_i;
      in_f = valid_i & ready_o;
      if (out_f) begin
        check("sb_has", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("sb_dat", 32'(dat_o), 32'(e));
        end
        n_out++;
        last_out = cyc;
      end
      if (in_f) begin
        exp_q.push_back(dat_i);
        last_acc = cyc;
      end
      stall_prev = valid_o & ~ready_i;
`ifdef DFF_PIPE_FLUSH_EN
      if (clr_i) begin
        exp_q.delete();
        stall_prev = 1'b0;
      end
`endif
      prev_d = dat_o;
      acc = in_f;
    end
  endtask

  initial begin
    rst_i = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    dat_i = 8'h00;
`ifdef DFF_PIPE_FLUSH_EN
    clr_i = 1'b0;
`endif
    fork
      forever begin
        @(negedge clk);
        monitor_cycle();
      end
      forever begin
        @(posedge clk);
        #1;
        if (drv_en) begin
          if (acc && valid_i) void'(src_q.pop_front());
          valid_i = (src_q.size() > 0) &&
                    ($urandom_range(99) < 32'(v_pct));
          dat_i = (src_q.size() > 0) ? src_q[0] : 8'($urandom);
          ready_i = ($urandom_range(99) < 32'(r_pct));
        end
      end
    join_none

    // reset
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_dat", 32'(dat_o), 32'(RV));
    check("rst_cnt", 32'(cnt_o), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd1);

    // single word latency
    v_pct = 100;
    r_pct = 100;
    src_q.push_back(8'h11);
    drv_en = 1'b1;
    for (int i = 0; i < 30 && n_out < 1; i++) begin
      @(negedge clk);
      #1;
    end
    check("single_out", 32'(n_out), 32'd1);
    check("latency", 32'(last_out - last_acc), 32'(ST));
    @(negedge clk);
    check("single_vo", 32'(valid_o), 32'd0);
    check("single_cnt", 32'(cnt_o), 32'd0);

    // fill while stalled, then drain in order
    r_pct = 0;
    for (int i = 1; i <= 4; i++) src_q.push_back(8'(i));
    repeat (8) @(negedge clk);
    #1;
    check("full_cnt", 32'(cnt_o), 32'd3);
    check("full_rdy", 32'(ready_o), 32'd0);
    check("full_left", 32'(src_q.size()), 32'd1);
    r_pct = 100;
    @(posedge clk);
    #2;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("drain_v", 32'(valid_o), 32'd1);
      check("drain_d", 32'(dat_o), 32'(k));
    end
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check("drain_n", 32'(n_out), 32'd5);

    // full pipe streaming
    r_pct = 0;
    for (int i = 0; i < 16; i++) src_q.push_back(8'(8'h20 + i));
    for (int i = 0; i < 30 && cnt_o != 2'd3; i++) begin
      @(negedge clk);
      #1;
    end
    check("strm_fill", 32'(cnt_o), 32'd3);
    r_pct = 100;
    @(posedge clk);
    #2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("strm_rdy", 32'(ready_o), 32'd1);
      check("strm_cnt", 32'(cnt_o), 32'd3);
      check("strm_d", 32'(dat_o), 32'(8'h20 + i));
    end
    for (int i = 0; i < 60 &&
         (exp_q.size() != 0 || src_q.size() != 0); i++) begin
      @(negedge clk);
      #1;
    end
    check("strm_n", 32'(n_out), 32'd21);

    // random handshakes
    v_pct = 50;
    r_pct = 50;
    for (int i = 0; i < 1000; i++) src_q.push_back(8'(i * 7 + 3));
    for (int i = 0; i < 20000 &&
         (exp_q.size() != 0 || src_q.size() != 0); i++) begin
      @(negedge clk);
      #1;
    end
    check("rand_n", 32'(n_out), 32'd1021);
    check("rand_q", 32'(exp_q.size()), 32'd0);

    // reset in the middle of traffic
    drv_en = 1'b0;
    @(posedge clk);
    #1;
    ready_i = 1'b0;
    valid_i = 1'b1;
    dat_i = 8'h31;
    @(posedge clk);
    #1 dat_i = 8'h32;
    @(posedge clk);
    #1;
    dat_i = 8'h33;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    valid_i = 1'b0;
    @(negedge clk);
    check("mrst_v", 32'(valid_o), 32'd0);
    check("mrst_cnt", 32'(cnt_o), 32'd0);
    check("mrst_dat", 32'(dat_o), 32'(RV));
    check("mrst_rdy", 32'(ready_o), 32'd1);

`ifdef DFF_PIPE_FLUSH_EN
    // flush with a word offered in the same cycle
    @(posedge clk);
    #1;
    valid_i = 1'b1;
    dat_i = 8'h55;
    @(posedge clk);
    #1 dat_i = 8'h66;
    @(posedge clk);
    #1;
    dat_i = 8'h77;
    clr_i = 1'b1;
    watch77 = 1'b1;
    @(negedge clk);
    check("fl_cnt2", 32'(cnt_o), 32'd2);
    check("fl_rdy", 32'(ready_o), 32'd0);
    @(posedge clk);
    #1;
    clr_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    check("fl_v", 32'(valid_o), 32'd0);
    check("fl_cnt", 32'(cnt_o), 32'd0);
    repeat (5) @(negedge clk);
    #1;
    check("fl_no77", 32'(saw77), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
